// File: rtl/t07_spi_pkg.sv
// Shared FSM encoding and default sizing for the ESP32 SPI receive path.
package t07_spi_pkg;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/t07_spi_rx_fifo.sv
// Word FIFO for received SPI data; a pop on a full FIFO frees the slot for a
// simultaneous push, and the count register alone decides full and empty.
module t07_spi_rx_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/t07_esp_spi_rx.sv
// SPI mode-0 receiver for words streamed by the ESP32; words are buffered in a
// small FIFO and popped one per MMIO read with a one-cycle acknowledge.
module t07_esp_spi_rx
  import t07_spi_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          esp_sclk_i,
  input  logic                          esp_cs_n_i,
  input  logic                          esp_mosi_i,
  input  logic                          espSPI_en,
  output logic [WORD_W-1:0]             SPIData_o,
  output logic                          SPIack_o,
  output logic                          overrun_o,
  output logic                          frame_err_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic              sclk_meta, sclk_sync, sclk_prev;
  logic              cs_meta, cs_sync;
  logic              mosi_meta, mosi_sync;
  logic              sclk_rise;

  spi_state_t        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;

  logic              push;
  logic              pop_req;
  logic [WORD_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  // Idle line levels (cs_n high, sclk/mosi low) are the reset values so that
  // leaving reset never looks like a frame start or a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= esp_sclk_i;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      cs_meta   <= esp_cs_n_i;
      cs_sync   <= cs_meta;
      mosi_meta <= esp_mosi_i;
      mosi_sync <= mosi_meta;
    end
  end

  assign sclk_rise = sclk_sync && !sclk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!cs_sync) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        SHIFT: begin
          // Chip select wins over a coincident clock edge: a frame ending
          // mid-word is dropped and flagged.
          if (cs_sync) begin
            if (bit_cnt != '0) frame_err_o <= 1'b1;
            state <= IDLE;
          end else if (sclk_rise) begin
            shreg   <= {shreg[WORD_W-2:0], mosi_sync};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(WORD_W - 1)) state <= COMMIT;
          end
        end
        COMMIT: begin
          bit_cnt <= '0;
          state   <= cs_sync ? IDLE : SHIFT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push    = (state == COMMIT);
  assign pop_req = espSPI_en && !fifo_empty;

  t07_spi_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop_req),
    .wdata (shreg),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt_o)
  );

  // A pop in the same cycle makes room, so only an unaccompanied push into a
  // full FIFO counts as an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      SPIData_o <= '0;
      SPIack_o  <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      SPIack_o <= pop_req;
      if (pop_req) SPIData_o <= fifo_rdata;
      if (push && fifo_full && !pop_req) overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_t07_esp_spi_rx.sv
// Self-checking bench: directed SPI scenarios plus random frames and reads,
// checked against a queue-based transaction model.
module tb_t07_esp_spi_rx;

  localparam int WORD_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        esp_sclk_i;
  logic                        esp_cs_n_i;
  logic                        esp_mosi_i;
  logic                        espSPI_en;
  logic [WORD_W-1:0]           SPIData_o;
  logic                        SPIack_o;
  logic                        overrun_o;
  logic                        frame_err_o;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] modelQ[$];
  logic [31:0] lastData;
  bit          modelOverrun;
  bit          modelFrameErr;
  bit          partialSent;

  t07_esp_spi_rx #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .esp_sclk_i  (esp_sclk_i),
    .esp_cs_n_i  (esp_cs_n_i),
    .esp_mosi_i  (esp_mosi_i),
    .espSPI_en   (espSPI_en),
    .SPIData_o   (SPIData_o),
    .SPIack_o    (SPIack_o),
    .overrun_o   (overrun_o),
    .frame_err_o (frame_err_o),
    .fifo_cnt_o  (fifo_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelPush(input logic [31:0] word);
    if (modelQ.size() < FIFO_DEPTH) modelQ.push_back(word);
    else modelOverrun = 1'b1;
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_cnt"}, 32'(fifo_cnt_o), 32'(modelQ.size()));
    checkOutput({tag, "_ovr"}, 32'(overrun_o), 32'(modelOverrun));
    checkOutput({tag, "_ferr"}, 32'(frame_err_o), 32'(modelFrameErr));
  endtask

  task automatic doReset();
    rst        = 1'b1;
    esp_cs_n_i = 1'b1;
    esp_sclk_i = 1'b0;
    esp_mosi_i = 1'b0;
    espSPI_en  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelQ.delete();
    lastData      = '0;
    modelOverrun  = 1'b0;
    modelFrameErr = 1'b0;
    partialSent   = 1'b0;
    checkOutput("rst_data", SPIData_o, 32'h0);
    checkOutput("rst_ack", 32'(SPIack_o), 32'h0);
    checkFlags("rst");
  endtask

  task automatic csLow();
    esp_cs_n_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic csHigh();
    esp_cs_n_i = 1'b1;
    repeat (6) @(negedge clk);
    if (partialSent) modelFrameErr = 1'b1;
    partialSent = 1'b0;
  endtask

  // Sends the top nbits of word MSB first, sclk period 8 clk. With popAtCommit
  // a one-cycle read lands on the cycle the completed word is committed.
  task automatic applyStimulus(input logic [31:0] word, input int nbits, input bit popAtCommit);
    logic expAck;
    for (int i = 31; i >= 32 - nbits; i--) begin
      esp_mosi_i = word[i];
      esp_sclk_i = 1'b0;
      repeat (4) @(negedge clk);
      esp_sclk_i = 1'b1;
      if (popAtCommit && i == 0) begin
        repeat (3) @(negedge clk);
        espSPI_en = 1'b1;
        @(negedge clk);
        espSPI_en = 1'b0;
        expAck = (modelQ.size() > 0);
        if (expAck) lastData = modelQ.pop_front();
        checkOutput("commit_ack", 32'(SPIack_o), 32'(expAck));
        checkOutput("commit_data", SPIData_o, lastData);
      end else begin
        repeat (4) @(negedge clk);
      end
    end
    esp_sclk_i = 1'b0;
    repeat (4) @(negedge clk);
    if (nbits == 32) modelPush(word);
    else partialSent = 1'b1;
  endtask

  // Holds the read request for n cycles; each cycle pops one word if any.
  task automatic popCheck(input int n);
    logic expAck;
    espSPI_en = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == n - 1) espSPI_en = 1'b0;
      expAck = (modelQ.size() > 0);
      if (expAck) lastData = modelQ.pop_front();
      checkOutput("pop_ack", 32'(SPIack_o), 32'(expAck));
      checkOutput("pop_data", SPIData_o, lastData);
      checkOutput("pop_cnt", 32'(fifo_cnt_o), 32'(modelQ.size()));
    end
    @(negedge clk);
    checkOutput("pop_ack_end", 32'(SPIack_o), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          op;
    int          k;
    logic [31:0] w;

    rst        = 1'b1;
    esp_cs_n_i = 1'b1;
    esp_sclk_i = 1'b0;
    esp_mosi_i = 1'b0;
    espSPI_en  = 1'b0;
    @(negedge clk);
    doReset();

    // Single word, single read
    csLow();
    applyStimulus(32'hA5C3_0F1E, 32, 1'b0);
    csHigh();
    checkFlags("single");
    popCheck(1);

    // Overfill with five words, then drain with single reads
    doReset();
    csLow();
    for (int i = 1; i <= 5; i++) applyStimulus(32'h1111_0000 + 32'(i), 32, 1'b0);
    csHigh();
    checkFlags("overfill");
    for (int i = 0; i < 5; i++) popCheck(1);

    // Truncated frame followed by a good word
    doReset();
    csLow();
    applyStimulus(32'hFFFF_FFFF, 17, 1'b0);
    csHigh();
    checkFlags("frame_err");
    csLow();
    applyStimulus(32'h1234_5678, 32, 1'b0);
    csHigh();
    checkFlags("after_err");
    popCheck(1);

    // Full FIFO, read coincides with commit of a fifth word
    doReset();
    csLow();
    for (int i = 0; i < 4; i++) applyStimulus(32'hC0DE_0000 + 32'(i), 32, 1'b0);
    applyStimulus(32'hC0DE_00FF, 32, 1'b1);
    csHigh();
    checkFlags("full_commit");
    popCheck(4);

    // Reset in the middle of a word with two words buffered
    doReset();
    csLow();
    applyStimulus(32'hAAAA_0001, 32, 1'b0);
    applyStimulus(32'hAAAA_0002, 32, 1'b0);
    csHigh();
    csLow();
    applyStimulus(32'h5555_5555, 10, 1'b0);
    doReset();
    csLow();
    applyStimulus(32'hDEAD_0001, 32, 1'b0);
    csHigh();
    checkFlags("post_reset");
    popCheck(1);

    // Back-to-back words in one frame
    doReset();
    csLow();
    applyStimulus(32'h0000_0001, 32, 1'b0);
    applyStimulus(32'h8000_0000, 32, 1'b0);
    csHigh();
    checkFlags("b2b");
    popCheck(2);

    // Random frames, truncated frames and held reads
    doReset();
    for (int it = 0; it < 25; it++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) begin
        k = int'($urandom_range(1, 3));
        csLow();
        for (int j = 0; j < k; j++) begin
          w = $urandom;
          applyStimulus(w, 32, $urandom_range(0, 3) == 0);
        end
        csHigh();
      end else if (op <= 7) begin
        csLow();
        w = $urandom;
        applyStimulus(w, int'($urandom_range(1, 31)), 1'b0);
        csHigh();
      end else begin
        popCheck(int'($urandom_range(1, 5)));
      end
      checkFlags("rand");
    end
    popCheck(FIFO_DEPTH + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
